// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle RISC-V style control unit.
//
// A Moore-style FSM sequences each instruction through fetch, decode and
// the execute/memory/writeback steps. The state is registered. The datapath
// controls are decoded combinationally from the state, the instruction
// fields and the ALU flags.
//
// Parameters
//   ALU_W       ALUControl width (>= 4); bits above [3:0] are always zero
//   EXT_BRANCH  1: beq/bne/blt/bge/bltu/bgeu legal; 0: beq only
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (returns to FETCH, clears retired)
//   op         opcode (valid outside FETCH)
//   funct3     instruction funct3
//   funct7     instruction bit 30
//   Zero, Lt, Ltu  ALU flags: result==0, signed a<b, unsigned a<b
//   mem_ready  memory access completes in the cycle this is high
//   PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc   datapath enables/selects
//   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc            datapath muxes
//   ALUControl ALU operation code
//   illegal    high while trapped on an illegal instruction
//   retired    count of completed instructions (wraps)
module mc_ctrl #(
  parameter int ALU_W      = 4,
  parameter bit EXT_BRANCH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             Ltu,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [ALU_W-1:0] ALUControl,
  output logic             illegal,
  output logic [31:0]      retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  state_t     state;
  state_t     state_nx;
  logic [3:0] alu_code;
  logic       retire;

  // funct3 selects the operation; funct7 only distinguishes sub (R-type
  // only, so addi with bit 30 set stays an add) and sra (R and I types).
  function automatic logic [3:0] alu_decode(input logic [6:0] o,
                                            input logic [2:0] f3,
                                            input logic       f7);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (o == OP_RTYPE && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  code = 4'b0111;
      3'b010:  code = 4'b0101;
      3'b011:  code = 4'b0110;
      3'b100:  code = 4'b0100;
      3'b101:  code = f7 ? 4'b1001 : 4'b1000;
      3'b110:  code = 4'b0011;
      default: code = 4'b0010;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] imm_decode(input logic [6:0] o);
    case (o)
      OP_STORE: return 2'b01;
      OP_BR:    return 2'b10;
      OP_JAL:   return 2'b11;
      default:  return 2'b00;
    endcase
  endfunction

  function automatic logic branch_legal(input logic [2:0] f3);
    if (f3 == 3'b010 || f3 == 3'b011) return 1'b0;
    if (!EXT_BRANCH && f3 != 3'b000)  return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic lt, input logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_nx  = state;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    alu_code  = ALU_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_nx = S_MEMADR;
          OP_RTYPE:          state_nx = S_EXECR;
          OP_ITYPE:          state_nx = S_EXECI;
          OP_BR:             state_nx = S_BRANCH;
          OP_JAL:            state_nx = S_JAL;
          default:           state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        state_nx = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_nx = S_FETCH;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_nx  = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_code = alu_decode(op, funct3, funct7);
        state_nx = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        state_nx = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 2'b10;
        alu_code = ALU_SUB;
        // An unsupported funct3 never redirects the PC; it traps instead.
        if (branch_legal(funct3)) begin
          PCWrite  = branch_taken(funct3, Zero, Lt, Ltu);
          state_nx = S_FETCH;
        end else begin
          state_nx = S_TRAP;
        end
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        PCWrite  = 1'b1;
        state_nx = S_ALUWB;
      end
      default: state_nx = S_TRAP;
    endcase
  end

  assign ALUControl = ALU_W'(alu_code);
  assign ImmSrc     = imm_decode(op);
  assign illegal    = (state == S_TRAP);

  // An instruction completes on leaving its last step for FETCH; JAL is
  // counted when its ALUWB step finishes.
  assign retire = (state_nx == S_FETCH) &&
                  (state == S_MEMWB || state == S_MEMWRITE ||
                   state == S_ALUWB || state == S_BRANCH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      retired <= 32'd0;
    end else begin
      state <= state_nx;
      if (retire) retired <= retired + 32'd1;
    end
  end

endmodule
